// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch via AR/PC, decode IR, Moore control outputs per state.
// Build option: define CU_ILLEGAL_OP_HALT_EN to send undefined opcodes to ENDOP instead of NOP.
module control_unit #(
   parameter int IR_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                Zout,
   input  logic [IR_WIDTH-1:0] instruction,
   output logic [2:0]          aluOp,
   output logic [3:0]          incReg,
   output logic [9:0]          wrEnReg,
   output logic [3:0]          busSel,
   output logic                DataMemWrEn,
   output logic                ZWrEn,
   output logic                done,
   output logic                ready
);

   typedef enum logic [IR_WIDTH-1:0] {
      OP_NOP, OP_ENDOP, OP_CLAC, OP_LDIAC, OP_LDAC, OP_STR, OP_STIR, OP_JUMP,
      OP_JMPNZ, OP_JMPZ, OP_MUL, OP_ADD, OP_SUB, OP_INCAC, OP_MV_RL_AC, OP_MV_RP_AC,
      OP_MV_RQ_AC, OP_MV_RC_AC, OP_MV_R_AC, OP_MV_R1_AC, OP_MV_AC_RP, OP_MV_AC_RQ, OP_MV_AC_RL
   } opcode_t;

   typedef enum logic [5:0] {
      S_IDLE, S_F1, S_F2, S_F3, S_NOP, S_ENDOP, S_CLAC, S_INCAC, S_ADD, S_SUB, S_MUL,
      S_MV_RL_AC, S_MV_RP_AC, S_MV_RQ_AC, S_MV_RC_AC, S_MV_R_AC, S_MV_R1_AC,
      S_MV_AC_RP, S_MV_AC_RQ, S_MV_AC_RL,
      S_L1, S_L2, S_L3, S_I1, S_I2, S_I3, S_I4, S_I5, S_S1, S_S2, S_S3,
      S_T1, S_T2, S_T3, S_T4, S_T5, S_J1, S_J2, S_J3, S_JMPZ, S_JMPNZ
   } state_t;

   localparam logic [2:0] ALU_IDLE = 3'd0, ALU_CLR = 3'd1, ALU_PASS = 3'd2, ALU_ADD = 3'd3,
                          ALU_SUB  = 3'd4, ALU_MUL = 3'd5, ALU_INC  = 3'd6;
   localparam logic [3:0] BUS_NONE = 4'd0, BUS_DM = 4'd1, BUS_PC = 4'd2, BUS_RL = 4'd4,
                          BUS_RC = 4'd5, BUS_RP = 4'd6, BUS_RQ = 4'd7, BUS_R = 4'd8,
                          BUS_R1 = 4'd9, BUS_AC = 4'd10;
   localparam logic [9:0] WR_AR = 10'h200, WR_R  = 10'h100, WR_PC = 10'h080, WR_IR = 10'h040,
                          WR_RL = 10'h020, WR_RC = 10'h010, WR_RP = 10'h008, WR_RQ = 10'h004,
                          WR_R1 = 10'h002, WR_AC = 10'h001;
   localparam logic [3:0] INC_PC = 4'b1000;

   state_t r_state;
   state_t w_next;
   state_t w_exec;
   logic   w_take;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // First execute state, chosen from the opcode presented during FETCH3
   always_comb begin
      w_exec = S_NOP;
      case (instruction)
         OP_NOP:      w_exec = S_NOP;
         OP_ENDOP:    w_exec = S_ENDOP;
         OP_CLAC:     w_exec = S_CLAC;
         OP_LDIAC:    w_exec = S_I1;
         OP_LDAC:     w_exec = S_L1;
         OP_STR:      w_exec = S_S1;
         OP_STIR:     w_exec = S_T1;
         OP_JUMP:     w_exec = S_J1;
         OP_JMPNZ:    w_exec = S_JMPNZ;
         OP_JMPZ:     w_exec = S_JMPZ;
         OP_MUL:      w_exec = S_MUL;
         OP_ADD:      w_exec = S_ADD;
         OP_SUB:      w_exec = S_SUB;
         OP_INCAC:    w_exec = S_INCAC;
         OP_MV_RL_AC: w_exec = S_MV_RL_AC;
         OP_MV_RP_AC: w_exec = S_MV_RP_AC;
         OP_MV_RQ_AC: w_exec = S_MV_RQ_AC;
         OP_MV_RC_AC: w_exec = S_MV_RC_AC;
         OP_MV_R_AC:  w_exec = S_MV_R_AC;
         OP_MV_R1_AC: w_exec = S_MV_R1_AC;
         OP_MV_AC_RP: w_exec = S_MV_AC_RP;
         OP_MV_AC_RQ: w_exec = S_MV_AC_RQ;
         OP_MV_AC_RL: w_exec = S_MV_AC_RL;
`ifdef CU_ILLEGAL_OP_HALT_EN
         default:     w_exec = S_ENDOP;
`else
         default:     w_exec = S_NOP;
`endif
      endcase
   end

   always_comb begin
      w_next      = r_state;
      aluOp       = ALU_IDLE;
      incReg      = '0;
      wrEnReg     = '0;
      busSel      = BUS_NONE;
      DataMemWrEn = 1'b0;
      ZWrEn       = 1'b0;
      done        = 1'b0;
      ready       = 1'b0;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE:  begin ready = 1'b1; if (start) w_next = S_F1; end
         S_F1:    begin busSel = BUS_PC; wrEnReg = WR_AR; w_next = S_F2; end
         S_F2:    w_next = S_F3;
         S_F3:    begin wrEnReg = WR_IR; incReg = INC_PC; w_next = w_exec; end
         S_NOP:   w_next = S_F1;
         S_ENDOP: begin done = 1'b1; w_next = S_IDLE; end
         S_CLAC:  begin aluOp = ALU_CLR; wrEnReg = WR_AC; ZWrEn = 1'b1; w_next = S_F1; end
         S_INCAC: begin aluOp = ALU_INC; wrEnReg = WR_AC; ZWrEn = 1'b1; w_next = S_F1; end
         S_ADD, S_SUB, S_MUL: begin
            aluOp   = (r_state == S_ADD) ? ALU_ADD : (r_state == S_SUB) ? ALU_SUB : ALU_MUL;
            busSel  = BUS_R;
            wrEnReg = WR_AC;
            ZWrEn   = 1'b1;
            w_next  = S_F1;
         end
         S_MV_RL_AC: begin busSel = BUS_AC; wrEnReg = WR_RL; w_next = S_F1; end
         S_MV_RP_AC: begin busSel = BUS_AC; wrEnReg = WR_RP; w_next = S_F1; end
         S_MV_RQ_AC: begin busSel = BUS_AC; wrEnReg = WR_RQ; w_next = S_F1; end
         S_MV_RC_AC: begin busSel = BUS_AC; wrEnReg = WR_RC; w_next = S_F1; end
         S_MV_R_AC:  begin busSel = BUS_AC; wrEnReg = WR_R;  w_next = S_F1; end
         S_MV_R1_AC: begin busSel = BUS_AC; wrEnReg = WR_R1; w_next = S_F1; end
         S_MV_AC_RP, S_MV_AC_RQ, S_MV_AC_RL: begin
            busSel  = (r_state == S_MV_AC_RP) ? BUS_RP : (r_state == S_MV_AC_RQ) ? BUS_RQ : BUS_RL;
            aluOp   = ALU_PASS;
            wrEnReg = WR_AC;
            ZWrEn   = 1'b1;
            w_next  = S_F1;
         end
         S_L1: begin busSel = BUS_AC; wrEnReg = WR_AR; w_next = S_L2; end
         S_L2: w_next = S_L3;
         S_L3: begin busSel = BUS_DM; aluOp = ALU_PASS; wrEnReg = WR_AC; ZWrEn = 1'b1; w_next = S_F1; end
         S_I1: begin busSel = BUS_PC; wrEnReg = WR_AR; w_next = S_I2; end
         S_I2: begin incReg = INC_PC; w_next = S_I3; end
         S_I3: begin busSel = BUS_DM; wrEnReg = WR_AR; w_next = S_I4; end
         S_I4: w_next = S_I5;
         S_I5: begin busSel = BUS_DM; aluOp = ALU_PASS; wrEnReg = WR_AC; ZWrEn = 1'b1; w_next = S_F1; end
         S_S1: begin busSel = BUS_AC; wrEnReg = WR_R; w_next = S_S2; end
         S_S2: begin DataMemWrEn = 1'b1; w_next = S_S3; end
         S_S3: w_next = S_F1;
         S_T1: begin busSel = BUS_PC; wrEnReg = WR_AR; w_next = S_T2; end
         S_T2: begin incReg = INC_PC; w_next = S_T3; end
         S_T3: begin busSel = BUS_DM; wrEnReg = WR_AR; w_next = S_T4; end
         S_T4: begin busSel = BUS_AC; wrEnReg = WR_R; w_next = S_T5; end
         S_T5: begin DataMemWrEn = 1'b1; w_next = S_F1; end
         S_J1: begin busSel = BUS_PC; wrEnReg = WR_AR; w_next = S_J2; end
         S_J2: w_next = S_J3;
         S_J3: begin busSel = BUS_DM; wrEnReg = WR_PC; w_next = S_F1; end
         // A taken branch doubles as J1 so the jump still totals six cycles
         S_JMPZ, S_JMPNZ: begin
            w_take = (r_state == S_JMPZ) ? Zout : ~Zout;
            if (w_take) begin
               busSel  = BUS_PC;
               wrEnReg = WR_AR;
               w_next  = S_J2;
            end else begin
               incReg  = INC_PC;
               w_next  = S_F1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomised instruction stream against a micro-step reference model; per-cycle scoreboard.
module tb_control_unit;

   typedef logic [24:0] ov_t;   // {aluOp, incReg, wrEnReg, busSel, DataMemWrEn, ZWrEn, done, ready}
   typedef struct {
      ov_t v;
      int  op;
      int  idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, start, Zout;
   logic [7:0] instruction;
   logic [2:0] aluOp;
   logic [3:0] incReg, busSel;
   logic [9:0] wrEnReg;
   logic       DataMemWrEn, ZWrEn, done, ready;
   ov_t        dut_out;

   exp_t q[$];
   ov_t  trace[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   tracking = 1'b0;

   always #5 clk = ~clk;

   control_unit #(.IR_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .Zout(Zout), .instruction(instruction),
      .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg), .busSel(busSel),
      .DataMemWrEn(DataMemWrEn), .ZWrEn(ZWrEn), .done(done), .ready(ready)
   );

   assign dut_out = {aluOp, incReg, wrEnReg, busSel, DataMemWrEn, ZWrEn, done, ready};

   // Reference encodings
   localparam logic [2:0] A0 = 3'd0, ACLR = 3'd1, APASS = 3'd2, AADD = 3'd3, ASUB = 3'd4,
                          AMUL = 3'd5, AINC = 3'd6;
   localparam logic [3:0] BN = 4'd0, BDM = 4'd1, BPC = 4'd2, BRL = 4'd4, BRC = 4'd5,
                          BRP = 4'd6, BRQ = 4'd7, BR = 4'd8, BR1 = 4'd9, BAC = 4'd10;

   function automatic logic [9:0] wr(input int bitpos);
      logic [9:0] one;
      one = 10'd1;
      return one << bitpos;
   endfunction

   function automatic ov_t mk(input logic [3:0] bus, input logic [2:0] alu, input logic [9:0] w,
                              input logic [3:0] inc, input bit dm, input bit zw,
                              input bit dn, input bit rdy);
      return {alu, inc, w, bus, dm, zw, dn, rdy};
   endfunction

   // Register indices in the write-enable vector
   localparam int AR = 9, R = 8, PC = 7, IR = 6, RL = 5, RC = 4, RP = 3, RQ = 2, R1 = 1, AC = 0;
   localparam logic [3:0] IPC = 4'b1000;

   function automatic ov_t idle_v();
      return mk(BN, A0, '0, '0, 0, 0, 0, 1);
   endfunction
   function automatic ov_t wait_v();
      return mk(BN, A0, '0, '0, 0, 0, 0, 0);
   endfunction
   function automatic ov_t mv(input logic [3:0] bus, input int dst);
      return mk(bus, A0, wr(dst), '0, 0, 0, 0, 0);
   endfunction
   function automatic ov_t alu_ac(input logic [3:0] bus, input logic [2:0] alu);
      return mk(bus, alu, wr(AC), '0, 0, 1, 0, 0);
   endfunction

   // Fills trace with the expected per-cycle outputs of one instruction; returns 1 if it halts
   function automatic bit build(input int op, input bit z);
      bit halts;
      int eff;
      halts = 0;
      trace.delete();
      trace.push_back(mv(BPC, AR));
      trace.push_back(wait_v());
      trace.push_back(mk(BN, A0, wr(IR), IPC, 0, 0, 0, 0));
      eff = op;
      if (op > 22) begin
`ifdef CU_ILLEGAL_OP_HALT_EN
         eff = 1;
`else
         eff = 0;
`endif
      end
      if (eff == 8) eff = z ? 100 : 7;   // JMPNZ: jump when Z clear
      else if (eff == 9) eff = z ? 7 : 100;
      case (eff)
         0:  trace.push_back(wait_v());
         1:  begin trace.push_back(mk(BN, A0, '0, '0, 0, 0, 1, 0)); halts = 1; end
         2:  trace.push_back(alu_ac(BN, ACLR));
         3:  begin
                trace.push_back(mv(BPC, AR));
                trace.push_back(mk(BN, A0, '0, IPC, 0, 0, 0, 0));
                trace.push_back(mv(BDM, AR));
                trace.push_back(wait_v());
                trace.push_back(alu_ac(BDM, APASS));
             end
         4:  begin
                trace.push_back(mv(BAC, AR));
                trace.push_back(wait_v());
                trace.push_back(alu_ac(BDM, APASS));
             end
         5:  begin
                trace.push_back(mv(BAC, R));
                trace.push_back(mk(BN, A0, '0, '0, 1, 0, 0, 0));
                trace.push_back(wait_v());
             end
         6:  begin
                trace.push_back(mv(BPC, AR));
                trace.push_back(mk(BN, A0, '0, IPC, 0, 0, 0, 0));
                trace.push_back(mv(BDM, AR));
                trace.push_back(mv(BAC, R));
                trace.push_back(mk(BN, A0, '0, '0, 1, 0, 0, 0));
             end
         7:  begin
                trace.push_back(mv(BPC, AR));
                trace.push_back(wait_v());
                trace.push_back(mv(BDM, PC));
             end
         100: trace.push_back(mk(BN, A0, '0, IPC, 0, 0, 0, 0));
         10: trace.push_back(alu_ac(BR, AMUL));
         11: trace.push_back(alu_ac(BR, AADD));
         12: trace.push_back(alu_ac(BR, ASUB));
         13: trace.push_back(alu_ac(BN, AINC));
         14: trace.push_back(mv(BAC, RL));
         15: trace.push_back(mv(BAC, RP));
         16: trace.push_back(mv(BAC, RQ));
         17: trace.push_back(mv(BAC, RC));
         18: trace.push_back(mv(BAC, R));
         19: trace.push_back(mv(BAC, R1));
         20: trace.push_back(alu_ac(BRP, APASS));
         21: trace.push_back(alu_ac(BRQ, APASS));
         22: trace.push_back(alu_ac(BRL, APASS));
         default: trace.push_back(wait_v());
      endcase
      return halts;
   endfunction

   // Pushes the expectation for the current cycle, then advances to just after the next edge
   task automatic step(input ov_t e, input int op, input int idx);
      exp_t x;
      x.v = e; x.op = op; x.idx = idx;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input int op, input bit z);
      bit halts;
      int n;
      halts = build(op, z);
      for (int i = 0; i < trace.size(); i++) begin
         start       = 1'($urandom);
         instruction = (i == 2) ? 8'(op) : 8'($urandom);
         Zout        = (i == 3 && (op == 8 || op == 9)) ? z : 1'($urandom);
         step(trace[i], op, i);
      end
      if (halts) begin
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            start = 1'b0;
            step(idle_v(), op, 100 + k);
         end
         start = 1'b1;
         step(idle_v(), op, 200);
      end
   endtask

   task automatic reset_mid_ldiac();
      void'(build(3, 1'b0));
      for (int i = 0; i < 5; i++) begin
         start       = 1'($urandom);
         instruction = (i == 2) ? 8'd3 : 8'($urandom);
         Zout        = 1'($urandom);
         rst         = (i == 4);
         step(trace[i], 3, i);
      end
      rst   = 1'b0;
      start = 1'b1;
      step(idle_v(), 3, 300);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (tracking) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL underflow t=%0t got=%h required=<expectation>", $time, dut_out);
         end else begin
            e = q.pop_front();
            if (dut_out !== e.v) begin
               n_fail++;
               $display("FAIL op%0d_step%0d got=%h required=%h", e.op, e.idx, dut_out, e.v);
            end
         end
      end
   end

   initial begin
      int op;
      rst = 1'b1; start = 1'b1; Zout = 1'b0; instruction = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      tracking = 1'b1;
      step(idle_v(), -1, 0);          // reset held with start high: stays IDLE
      rst = 1'b0; start = 1'b1;
      step(idle_v(), -1, 1);          // one ready cycle, then FETCH1
      // Directed boundary cases first
      run_instr(2, 1'b0);
      run_instr(9, 1'b1);
      run_instr(9, 1'b0);
      run_instr(8, 1'b0);
      run_instr(8, 1'b1);
      run_instr(3, 1'b0);
      run_instr(6, 1'b0);
      run_instr(1, 1'b0);
      run_instr(200, 1'b0);
      reset_mid_ldiac();
      for (int n = 0; n < 300; n++) begin
         op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(23, 255)) : int'($urandom_range(0, 22));
         run_instr(op, 1'($urandom));
      end
      run_instr(1, 1'b0);
      tracking = 1'b0;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
